// File: rtl/regfile_wb_arbiter.sv
// Two-source arbiter for the register file write port, req0 has priority.
// Define WB_FAIR_EN to add the req1 starvation counter and FORCE1 state.
module regfile_wb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int STARVE_MAX = 4
) (
   input  logic              Clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_rd,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_rd,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              write,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] entradaWb,
   output logic              grant_id
);

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_chk
      $error("STARVE_MAX out of range 1..15");
   end

   logic xfer0;
   logic xfer1;

   assign xfer0 = req0_valid & req0_ready;
   assign xfer1 = req1_valid & req1_ready;

`ifdef WB_FAIR_EN
   typedef enum logic {
      PRIO0,
      FORCE1
   } state_t;

   localparam logic [3:0] LIM = 4'(STARVE_MAX);

   state_t     state;
   state_t     state_n;
   logic [3:0] cnt;
   logic [3:0] cnt_n;

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      state_n    = state;
      cnt_n      = 4'd0;
      if (!rst) begin
         unique case (state)
            PRIO0: begin
               req0_ready = req0_valid;
               req1_ready = req1_valid & ~req0_valid;
            end
            FORCE1: begin
               req1_ready = req1_valid;
               req0_ready = ~req1_valid & req0_valid;
            end
            default: ;
         endcase
      end
      // Saturating count of consecutive denied req1 cycles
      if (req1_valid && !req1_ready)
         cnt_n = (cnt >= LIM) ? LIM : cnt + 4'd1;
      unique case (state)
         PRIO0:
            if (cnt_n == LIM)
               state_n = FORCE1;
         FORCE1:
            if (!req1_valid || req1_ready)
               state_n = PRIO0;
         default: state_n = PRIO0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (rst) begin
         state <= PRIO0;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end
`else
   always_comb begin
      req0_ready = ~rst & req0_valid;
      req1_ready = ~rst & req1_valid & ~req0_valid;
   end
`endif

   // Writes to $0 are accepted but never reach the port
   always_ff @(posedge Clk) begin
      if (rst) begin
         write     <= 1'b0;
         rd        <= '0;
         entradaWb <= '0;
         grant_id  <= 1'b0;
      end else if (xfer0) begin
         write <= (req0_rd != '0);
         if (req0_rd != '0) begin
            rd        <= req0_rd;
            entradaWb <= req0_data;
            grant_id  <= 1'b0;
         end
      end else if (xfer1) begin
         write <= (req1_rd != '0);
         if (req1_rd != '0) begin
            rd        <= req1_rd;
            entradaWb <= req1_data;
            grant_id  <= 1'b1;
         end
      end else begin
         write <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register file model.
// Starvation expectations follow WB_FAIR_EN.
module tb_regfile_wb_arbiter;

   logic        Clk;
   logic        rst;
   logic        req0_valid;
   logic [4:0]  req0_rd;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [4:0]  req1_rd;
   logic [31:0] req1_data;
   logic        req1_ready;
   logic        write;
   logic [4:0]  rd;
   logic [31:0] entradaWb;
   logic        grant_id;

   logic [31:0] rf [32];
   int          n_chk;
   int          n_err;

   regfile_wb_arbiter #(
      .DATA_W(32),
      .ADDR_W(5),
      .STARVE_MAX(4)
   ) dut (
      .Clk(Clk),
      .rst(rst),
      .req0_valid(req0_valid),
      .req0_rd(req0_rd),
      .req0_data(req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid),
      .req1_rd(req1_rd),
      .req1_data(req1_data),
      .req1_ready(req1_ready),
      .write(write),
      .rd(rd),
      .entradaWb(entradaWb),
      .grant_id(grant_id)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Register file model fed by the arbiter's write port
   always @(posedge Clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++)
            rf[i] <= 32'h0;
      end else if (write) begin
         rf[rd] <= entradaWb;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_wr(input string tag,
                         input logic        w,
                         input logic [4:0]  a,
                         input logic [31:0] d,
                         input logic        g);
      chk({tag, ".write"}, 32'(write), 32'(w));
      chk({tag, ".rd"}, 32'(rd), 32'(a));
      chk({tag, ".data"}, entradaWb, d);
      chk({tag, ".gid"}, 32'(grant_id), 32'(g));
   endtask

   initial begin
      n_chk      = 0;
      n_err      = 0;
      rst        = 1'b1;
      req0_valid = 1'b1;
      req0_rd    = 5'd3;
      req0_data  = 32'h11;
      req1_valid = 1'b1;
      req1_rd    = 5'd4;
      req1_data  = 32'h22;
      tick();
      tick();
      chk("rst.r0", 32'(req0_ready), 32'd0);
      chk("rst.r1", 32'(req1_ready), 32'd0);
      chk_wr("rst", 1'b0, 5'd0, 32'h0, 1'b0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst        = 1'b0;
      tick();
      chk_wr("idle", 1'b0, 5'd0, 32'h0, 1'b0);

      // single write
      req0_valid = 1'b1;
      req0_rd    = 5'h1;
      req0_data  = 32'ha0a0a0a0;
      #1;
      chk("single.r0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      chk_wr("single", 1'b1, 5'h1, 32'ha0a0a0a0, 1'b0);
      tick();
      chk_wr("single.after", 1'b0, 5'h1, 32'ha0a0a0a0, 1'b0);
      chk("single.rf1", rf[1], 32'ha0a0a0a0);

      // conflict
      req0_valid = 1'b1;
      req0_rd    = 5'h2;
      req0_data  = 32'hffffffff;
      req1_valid = 1'b1;
      req1_rd    = 5'h1c;
      req1_data  = 32'h19857328;
      #1;
      chk("conf.r0", 32'(req0_ready), 32'd1);
      chk("conf.r1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      chk_wr("conf.n1", 1'b1, 5'h2, 32'hffffffff, 1'b0);
      #1;
      chk("conf.r1b", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      chk_wr("conf.n2", 1'b1, 5'h1c, 32'h19857328, 1'b1);
      tick();
      chk("conf.idle", 32'(write), 32'd0);

      // write to $0 is dropped
      req1_valid = 1'b1;
      req1_rd    = 5'h0;
      req1_data  = 32'hdeadbeef;
      #1;
      chk("z.r1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      chk_wr("z", 1'b0, 5'h1c, 32'h19857328, 1'b1);
      tick();
      chk("z.rf0", rf[0], 32'h0);
      chk("z.rf1c", rf[28], 32'h19857328);

      // back-to-back
      for (int i = 1; i <= 4; i++) begin
         req0_valid = 1'b1;
         req0_rd    = 5'(i);
         req0_data  = 32'h100 + 32'(i);
         tick();
         chk_wr($sformatf("b2b%0d", i), 1'b1, 5'(i),
                32'h100 + 32'(i), 1'b0);
      end
      req0_valid = 1'b0;
      tick();
      chk("b2b.end", 32'(write), 32'd0);

      // starvation
      req1_valid = 1'b1;
      req1_rd    = 5'h1f;
      req1_data  = 32'h753b9817;
      req0_valid = 1'b1;
      req0_data  = 32'h5a5a0000;
`ifdef WB_FAIR_EN
      for (int c = 1; c <= 5; c++) begin
         req0_rd = 5'(c);
         #1;
         chk($sformatf("st%0d.r1", c), 32'(req1_ready),
             32'(c == 5));
         chk($sformatf("st%0d.r0", c), 32'(req0_ready),
             32'(c != 5));
         tick();
      end
      req1_valid = 1'b0;
      chk_wr("st.force", 1'b1, 5'h1f, 32'h753b9817, 1'b1);
      #1;
      chk("st.resume.r0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      chk_wr("st.resume", 1'b1, 5'h5, 32'h5a5a0000, 1'b0);
`else
      for (int c = 1; c <= 20; c++) begin
         req0_rd = 5'(c);
         #1;
         chk($sformatf("st%0d.r1", c), 32'(req1_ready), 32'd0);
         tick();
      end
      req0_valid = 1'b0;
      #1;
      chk("st.late.r1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      chk_wr("st.late", 1'b1, 5'h1f, 32'h753b9817, 1'b1);
`endif
      tick();
      chk("st.idle", 32'(write), 32'd0);

      // reset mid-stream
      req0_valid = 1'b1;
      req0_rd    = 5'h7;
      req0_data  = 32'h77;
      tick();
      chk_wr("mr.pre", 1'b1, 5'h7, 32'h77, 1'b0);
      rst       = 1'b1;
      req0_rd   = 5'h8;
      req0_data = 32'h88;
      #1;
      chk("mr.r0", 32'(req0_ready), 32'd0);
      tick();
      rst = 1'b0;
      chk_wr("mr.rst", 1'b0, 5'h0, 32'h0, 1'b0);
      #1;
      chk("mr.r0b", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      chk_wr("mr.post", 1'b1, 5'h8, 32'h88, 1'b0);
      tick();
      chk("mr.nodup", 32'(write), 32'd0);
      chk("mr.rf8", rf[8], 32'h88);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
